// File: rtl/ifetch_queue_if.sv
// ---------------------------------------------------------------------------
// ifetch_queue_if
//   Instruction-memory bus between the fetch queue and the memory system.
//
//   mem_req_valid  fetch unit -> memory   request valid
//   mem_req_addr   fetch unit -> memory   request address (PC_W)
//   mem_req_ready  memory -> fetch unit   request accepted when valid & ready
//   mem_rsp_valid  memory -> fetch unit   in-order response, always accepted
//   mem_rsp_data   memory -> fetch unit   response instruction (INST_W)
//
//   modport master : the fetch unit (ifetch_queue)
//   modport slave  : the memory system
// ---------------------------------------------------------------------------
interface ifetch_queue_if #(
    parameter int PC_W   = 32,
    parameter int INST_W = 32
);
    logic              mem_req_valid;
    logic [PC_W-1:0]   mem_req_addr;
    logic              mem_req_ready;
    logic              mem_rsp_valid;
    logic [INST_W-1:0] mem_rsp_data;

    modport master (
        output mem_req_valid,
        output mem_req_addr,
        input  mem_req_ready,
        input  mem_rsp_valid,
        input  mem_rsp_data
    );

    modport slave (
        input  mem_req_valid,
        input  mem_req_addr,
        output mem_req_ready,
        output mem_rsp_valid,
        output mem_rsp_data
    );
endinterface

// File: rtl/ifetch_queue.sv
// ---------------------------------------------------------------------------
// ifetch_queue
//   Instruction fetch unit with a small decoupling queue. Issues sequential
//   fetch requests (PC += 4), tracks request PCs in an in-order tag FIFO,
//   writes returning instructions into a DEPTH-entry queue and hands them to
//   decode. A redirect flushes the queue and restarts fetch; responses to
//   requests already in flight are counted in drop_cnt and discarded.
//
//   Ports
//     clk_in          clock, all state on the rising edge
//     rst_in          synchronous, active-high reset
//     redirect_valid  flush and restart fetch at redirect_pc
//     redirect_pc     new fetch PC
//     deq_ready       decode consumes the head entry when out_valid=1
//     out_valid       queue head valid
//     out_pc          head PC
//     out_inst        head instruction
//     mem             ifetch_queue_if.master, memory request/response bus
//
//   Optional feature (macro IFETCH_PERF_EN)
//     perf_fetched    32-bit wrapping count of responses written to the queue
//     perf_dropped    32-bit wrapping count of discarded responses
// ---------------------------------------------------------------------------
module ifetch_queue #(
    parameter int              PC_W     = 32,
    parameter int              INST_W   = 32,
    parameter int              DEPTH    = 4,
    parameter int              MAX_OUT  = 2,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    input  logic              deq_ready,
    output logic              out_valid,
    output logic [PC_W-1:0]   out_pc,
    output logic [INST_W-1:0] out_inst,
    ifetch_queue_if.master    mem
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_dropped
`endif
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int TAG_PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int SUM_W  = CNT_W + 1;

    // Architectural state
    logic [PC_W-1:0]   fetch_pc;
    logic              req_valid_q;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  occ;        // entries held in the queue
    logic [CNT_W-1:0]  live_cnt;   // requests in flight whose responses are kept
    logic [CNT_W-1:0]  drop_cnt;   // requests in flight whose responses are discarded
    logic [TAG_PW-1:0] tag_rd;
    logic [TAG_PW-1:0] tag_wr;

    logic [PC_W-1:0]   q_pc   [DEPTH];
    logic [INST_W-1:0] q_inst [DEPTH];
    logic [PC_W-1:0]   tag_pc [MAX_OUT];

    // Handshake decode
    logic req_fire;
    logic rsp_fire;
    logic rsp_drop;
    logic rsp_live;
    logic enq;
    logic deq;

    // Reset gates the request combinationally so nothing can be accepted
    // during the reset cycle itself; the rest of the path is a flop.
    assign mem.mem_req_valid = req_valid_q & ~rst_in;
    assign mem.mem_req_addr  = fetch_pc;

    assign req_fire = mem.mem_req_valid & mem.mem_req_ready;
    assign rsp_fire = mem.mem_rsp_valid & ~rst_in;
    assign rsp_drop = rsp_fire & (drop_cnt != '0);
    assign rsp_live = rsp_fire & (drop_cnt == '0);
    // A live response arriving in a redirect cycle belongs to the annulled
    // path, so it is not written.
    assign enq      = rsp_live & ~redirect_valid;
    assign deq      = out_valid & deq_ready & ~redirect_valid;

    assign out_valid = (occ != '0);
    assign out_pc    = q_pc[head];
    assign out_inst  = q_inst[head];

    function automatic logic [TAG_PW-1:0] tag_next(input logic [TAG_PW-1:0] p);
        return (p == TAG_PW'(MAX_OUT - 1)) ? '0 : p + TAG_PW'(1);
    endfunction

    // Next-state counters
    logic [CNT_W-1:0] occ_n;
    logic [CNT_W-1:0] live_n;
    logic [CNT_W-1:0] drop_n;
    logic             req_valid_d;

    // NOTE: every signal written in an always_comb gets a default on entry;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        occ_n  = occ;
        live_n = live_cnt;
        drop_n = drop_cnt;
        if (redirect_valid) begin
            // Everything in flight, including a request accepted this very
            // cycle, becomes stale; a response consumed this cycle is gone.
            occ_n  = '0;
            live_n = '0;
            drop_n = drop_cnt + live_cnt + CNT_W'(req_fire) - CNT_W'(rsp_fire);
        end else begin
            occ_n  = occ + CNT_W'(enq) - CNT_W'(deq);
            live_n = live_cnt + CNT_W'(req_fire) - CNT_W'(rsp_live);
            drop_n = drop_cnt - CNT_W'(rsp_drop);
        end
    end

    // Queue space only has to be reserved for live requests (stale responses
    // never land), while the in-flight cap counts stale ones too. Evaluated on
    // next-state values, so once raised the request stays legal until it is
    // accepted: without a handshake, occ+live and live+drop can only shrink.
    assign req_valid_d = (({1'b0, occ_n} + {1'b0, live_n}) < SUM_W'(DEPTH)) &&
                         (({1'b0, live_n} + {1'b0, drop_n}) < SUM_W'(MAX_OUT));

    // NOTE: sequential state is assigned with non-blocking (<=) only, so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            fetch_pc    <= RESET_PC;
            req_valid_q <= 1'b0;
            head        <= '0;
            tail        <= '0;
            occ         <= '0;
            live_cnt    <= '0;
            drop_cnt    <= '0;
            tag_rd      <= '0;
            tag_wr      <= '0;
        end else begin
            occ         <= occ_n;
            live_cnt    <= live_n;
            drop_cnt    <= drop_n;
            req_valid_q <= req_valid_d;
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
                head     <= '0;
                tail     <= '0;
                tag_rd   <= '0;
                tag_wr   <= '0;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + PC_W'(4);
                    tag_wr   <= tag_next(tag_wr);
                end
                if (rsp_live) tag_rd <= tag_next(tag_rd);
                if (enq)      tail   <= tail + PTR_W'(1);
                if (deq)      head   <= head + PTR_W'(1);
            end
        end
    end

    // NOTE: storage arrays are deliberately not reset; occupancy and pointers
    // decide what is valid, so stale contents are never observed.
    always_ff @(posedge clk_in) begin
        if (enq) begin
            q_pc[tail]   <= tag_pc[tag_rd];
            q_inst[tail] <= mem.mem_rsp_data;
        end
        if (req_fire && !redirect_valid) begin
            tag_pc[tag_wr] <= fetch_pc;
        end
    end

`ifdef IFETCH_PERF_EN
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            perf_fetched <= '0;
            perf_dropped <= '0;
        end else begin
            if (enq) perf_fetched <= perf_fetched + 32'd1;
            if (rsp_drop || (rsp_live && redirect_valid)) perf_dropped <= perf_dropped + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// ---------------------------------------------------------------------------
// tb_ifetch_queue
//   Directed bench for ifetch_queue (DEPTH=4, MAX_OUT=2, RESET_PC=0).
//   Inputs change on the falling edge; a memory responder returns
//   inst = addr ^ 0xDEAD0000 one cycle after each accepted request, and can
//   hold responses back on demand.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ifetch_queue;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        deq_ready;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_dropped;
`endif

    ifetch_queue_if #(.PC_W(32), .INST_W(32)) bus ();

    ifetch_queue #(
        .PC_W(32), .INST_W(32), .DEPTH(4), .MAX_OUT(2), .RESET_PC(32'h0)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .deq_ready     (deq_ready),
        .out_valid     (out_valid),
        .out_pc        (out_pc),
        .out_inst      (out_inst),
        .mem           (bus)
`ifdef IFETCH_PERF_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_dropped  (perf_dropped)
`endif
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    // Memory responder and decode-side monitor
    bit          ready_en = 1'b0;
    bit          rsp_hold = 1'b0;
    logic [31:0] pend[$];
    logic [31:0] req_log[$];
    logic [31:0] dq_pc[$];
    logic [31:0] dq_inst[$];

    initial begin
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
        forever begin
            @(negedge clk_in);
            #1;
            if (!rsp_hold && pend.size() > 0) begin
                bus.mem_rsp_valid = 1'b1;
                bus.mem_rsp_data  = inst_of(pend.pop_front());
            end else begin
                bus.mem_rsp_valid = 1'b0;
            end
            bus.mem_req_ready = ready_en;
            if (bus.mem_req_valid && bus.mem_req_ready) begin
                pend.push_back(bus.mem_req_addr);
                req_log.push_back(bus.mem_req_addr);
            end
            if (out_valid && deq_ready && !redirect_valid) begin
                dq_pc.push_back(out_pc);
                dq_inst.push_back(out_inst);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst_in = 1'b1; redirect_valid = 1'b0; deq_ready = 1'b0;
        ready_en = 1'b0; rsp_hold = 1'b0;
        #2;
        check("rst_gates_req_valid", bus.mem_req_valid, 0);
        cycles(3);
        req_log.delete(); dq_pc.delete(); dq_inst.delete();
        rst_in = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; deq_ready = 1'b0;

        // Reset state
        cycles(2); #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_req_valid", bus.mem_req_valid, 0);
        cycles(1);
        rst_in = 1'b0; #2;
        check("rst_req_addr", bus.mem_req_addr, 32'h0);
        cycles(1); #2;
        check("rst_first_req_valid", bus.mem_req_valid, 1);

        // Streaming fetch: sequential addresses, in-order delivery
        do_reset();
        ready_en = 1'b1; deq_ready = 1'b1;
        cycles(16);
        ready_en = 1'b0;
        cycles(6); #2;
        check("s_req_cnt_ge6", req_log.size() >= 6, 1);
        check("s_deq_cnt_ge6", dq_pc.size() >= 6, 1);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("s_addr%0d", i), req_log[i], 32'(4 * i));
            check($sformatf("s_pc%0d", i), dq_pc[i], 32'(4 * i));
            check($sformatf("s_inst%0d", i), dq_inst[i], inst_of(32'(4 * i)));
        end
        check("s_all_delivered", dq_pc.size(), req_log.size());

        // Backpressure: exactly DEPTH requests, then one per dequeue
        do_reset();
        ready_en = 1'b1;
        cycles(10); #2;
        check("bp_req_cnt", req_log.size(), 4);
        check("bp_req_valid", bus.mem_req_valid, 0);
        check("bp_head_pc", out_pc, 32'h0);
        check("bp_head_inst", out_inst, 32'hDEAD_0000);
        cycles(1); rsp_hold = 1'b1; deq_ready = 1'b1;
        cycles(1); deq_ready = 1'b0;
        cycles(5); #2;
        check("bp_req_cnt_after_deq", req_log.size(), 5);
        check("bp_new_addr", req_log[4], 32'h10);
        check("bp_req_valid_after", bus.mem_req_valid, 0);
        check("bp_head_pc_after", out_pc, 32'h4);

        // Enqueue and dequeue in the same cycle with every slot committed
        cycles(1); ready_en = 1'b0; rsp_hold = 1'b0; deq_ready = 1'b1;
        cycles(1); deq_ready = 1'b0; #2;
        check("sim_out_valid", out_valid, 1);
        check("sim_head_pc", out_pc, 32'h8);
        cycles(1); deq_ready = 1'b1;
        cycles(6); #2;
        check("sim_deq_cnt", dq_pc.size(), 5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("sim_pc%0d", i), dq_pc[i], 32'(4 * i));
        end
        check("sim_inst4", dq_inst[4], 32'hDEAD_0010);
        check("sim_drained", out_valid, 0);
        check("sim_hold_valid", bus.mem_req_valid, 1);
        check("sim_hold_addr", bus.mem_req_addr, 32'h14);

        // Redirect to 0x100 with two requests in flight
        do_reset();
        ready_en = 1'b1; rsp_hold = 1'b1; deq_ready = 1'b1;
        cycles(5); #2;
        check("rd1_outstanding", req_log.size(), 2);
        check("rd1_cap_valid", bus.mem_req_valid, 0);
        cycles(1); redirect_valid = 1'b1; redirect_pc = 32'h100;
        cycles(1); redirect_valid = 1'b0; rsp_hold = 1'b0; #2;
        check("rd1_out_valid", out_valid, 0);
        check("rd1_addr", bus.mem_req_addr, 32'h100);
        check("rd1_stale_block", bus.mem_req_valid, 0);
        cycles(10); ready_en = 1'b0;
        cycles(4); #2;
        check("rd1_first_pc", dq_pc[0], 32'h100);
        check("rd1_first_inst", dq_inst[0], 32'hDEAD_0100);
        check("rd1_second_pc", dq_pc[1], 32'h104);
        begin
            int stale = 0;
            foreach (dq_pc[i]) if (dq_pc[i] < 32'h100) stale++;
            check("rd1_no_stale", stale, 0);
        end
`ifdef IFETCH_PERF_EN
        check("rd1_perf_dropped", perf_dropped, 2);
        check("rd1_perf_fetched", perf_fetched, dq_pc.size());
`endif

        // Back-to-back redirects 0x200 then 0x300, one request in flight
        do_reset();
        rsp_hold = 1'b1; deq_ready = 1'b1;
        cycles(2); #2;
        check("rd2_valid0", bus.mem_req_valid, 1);
        cycles(1); ready_en = 1'b1;
        cycles(1); ready_en = 1'b0; #2;
        check("rd2_addr4", bus.mem_req_addr, 32'h4);
        cycles(1); redirect_valid = 1'b1; redirect_pc = 32'h200;
        cycles(1); redirect_pc = 32'h300; ready_en = 1'b1; #2;
        check("rd2_mid_valid", bus.mem_req_valid, 1);
        check("rd2_mid_addr", bus.mem_req_addr, 32'h200);
        cycles(1); redirect_valid = 1'b0; rsp_hold = 1'b0; #2;
        check("rd2_block", bus.mem_req_valid, 0);
        check("rd2_addr", bus.mem_req_addr, 32'h300);
        cycles(10); ready_en = 1'b0;
        cycles(4); #2;
        check("rd2_req1", req_log[1], 32'h200);
        check("rd2_req2", req_log[2], 32'h300);
        check("rd2_first_pc", dq_pc[0], 32'h300);
        check("rd2_first_inst", dq_inst[0], 32'hDEAD_0300);
`ifdef IFETCH_PERF_EN
        check("rd2_perf_dropped", perf_dropped, 2);
`endif

        // Reset mid-stream with two requests outstanding; reset beats redirect
        do_reset();
        ready_en = 1'b1;
        cycles(3); rsp_hold = 1'b1;
        cycles(3); #2;
        check("mr_pre_valid", out_valid, 1);
        check("mr_pre_pc", out_pc, 32'h0);
        cycles(1); rst_in = 1'b1; rsp_hold = 1'b0;
        cycles(1); redirect_valid = 1'b1; redirect_pc = 32'h500;
        cycles(1); redirect_valid = 1'b0;
        cycles(1);
        req_log.delete(); dq_pc.delete(); dq_inst.delete();
        rst_in = 1'b0; #2;
        check("mr_out_valid", out_valid, 0);
        check("mr_addr", bus.mem_req_addr, 32'h0);
`ifdef IFETCH_PERF_EN
        check("mr_perf_fetched", perf_fetched, 0);
`endif
        cycles(1); #2;
        check("mr_req_valid", bus.mem_req_valid, 1);
        cycles(1); deq_ready = 1'b1;
        cycles(10); ready_en = 1'b0;
        cycles(4); #2;
        check("mr_first_pc", dq_pc[0], 32'h0);
        check("mr_first_inst", dq_inst[0], 32'hDEAD_0000);
        check("mr_second_pc", dq_pc[1], 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
